// File: rtl/bcd_converter_seq.sv
// -----------------------------------------------------------------------------
// bcd_converter_seq
//
// Sequential binary-to-BCD converter using the shift-add-3 (double dabble)
// algorithm, one operand bit per clock, MSB first.
//
// A conversion is accepted from IDLE on a rising edge with start=1. It runs
// BIN_WIDTH SHIFT cycles and then one FINISH cycle. The FINISH cycle publishes
// the result registers and pulses done. The result is bin mod 10^DEC_WIDTH.
// ovf flags operands that do not fit in DEC_WIDTH digits.
//
// Parameters:
//   BIN_WIDTH  binary operand width (1..32)
//   DEC_WIDTH  number of BCD output digits (1..10)
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   conversion request, honoured only while idle
//   bin    in   unsigned operand, captured on the edge that accepts start
//   busy   out  conversion in progress (SHIFT or FINISH)
//   done   out  one-cycle pulse, bcd/ovf valid from this cycle on
//   bcd    out  packed BCD result, digit k in [4k+3:4k]
//   ovf    out  operand >= 10^DEC_WIDTH
// -----------------------------------------------------------------------------
module bcd_converter_seq #(
    parameter int BIN_WIDTH = 16,
    parameter int DEC_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [BIN_WIDTH-1:0]   bin,
    output logic                   busy,
    output logic                   done,
    output logic [DEC_WIDTH*4-1:0] bcd,
    output logic                   ovf
);

    localparam int BCD_W = DEC_WIDTH * 4;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FINISH
    } state_t;

    state_t               r_state;
    logic [BIN_WIDTH-1:0] r_shift;
    logic [BCD_W-1:0]     r_digits;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ovf_int;
    logic [BCD_W-1:0]     r_bcd;
    logic                 r_ovf;
    logic                 r_busy;
    logic                 r_done;

    logic [BCD_W-1:0]     w_adj;
    logic [BCD_W-1:0]     w_digits_next;
    logic                 w_carry;

    // Add-3 correction on every digit that would reach 10 or more when doubled.
    generate
        for (genvar gi = 0; gi < DEC_WIDTH; gi++) begin : g_adj
            assign w_adj[gi*4 +: 4] = (r_digits[gi*4 +: 4] >= 4'd5)
                                    ? r_digits[gi*4 +: 4] + 4'd3
                                    : r_digits[gi*4 +: 4];
        end
    endgenerate

    // Shift the corrected chain left by one. The operand MSB enters digit 0.
    // The bit leaving the top digit is a carry past the last digit, so the
    // operand is too large for DEC_WIDTH digits.
    assign w_digits_next = {w_adj[BCD_W-2:0], r_shift[BIN_WIDTH-1]};
    assign w_carry       = w_adj[BCD_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_digits  <= '0;
            r_cnt     <= '0;
            r_ovf_int <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift   <= bin;
                        r_digits  <= '0;
                        r_ovf_int <= 1'b0;
                        r_cnt     <= CNT_LOAD;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_digits <= w_digits_next;
                    r_shift  <= r_shift << 1;
                    r_cnt    <= r_cnt - CNT_ONE;
                    if (w_carry) begin
                        r_ovf_int <= 1'b1;
                    end
                    // The count reaches zero on the last shift. Because FINISH
                    // does not decrement it, it never wraps.
                    if (r_cnt == CNT_ONE) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_bcd   <= r_digits;
                    r_ovf   <= r_ovf_int;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_bcd_converter_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd_converter_seq
//
// Three instances of bcd_converter_seq: the default configuration, a 4-digit
// variant that can overflow, and a minimal 1-bit / 1-digit variant.
// A table of directed vectors runs back-to-back, and each new start lands in
// the previous done cycle. Hand-written sequences cover start-while-busy and
// reset-mid-conversion.
// -----------------------------------------------------------------------------
module tb_bcd_converter_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start0, start1, start2;
    logic [15:0] bin0, bin1;
    logic [0:0]  bin2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [19:0] bcd0;
    logic [15:0] bcd1;
    logic [3:0]  bcd2;
    logic        ovf0, ovf1, ovf2;

    bcd_converter_seq #(.BIN_WIDTH(16), .DEC_WIDTH(5)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .bin(bin0),
        .busy(busy0), .done(done0), .bcd(bcd0), .ovf(ovf0)
    );

    bcd_converter_seq #(.BIN_WIDTH(16), .DEC_WIDTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bin(bin1),
        .busy(busy1), .done(done1), .bcd(bcd1), .ovf(ovf1)
    );

    bcd_converter_seq #(.BIN_WIDTH(1), .DEC_WIDTH(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
    );

    // Select the outputs of the instance under test.
    int          cur;
    logic        s_busy, s_done, s_ovf;
    logic [19:0] s_bcd;

    always_comb begin
        s_busy = busy0;
        s_done = done0;
        s_ovf  = ovf0;
        s_bcd  = bcd0;
        case (cur)
            1: begin
                s_busy = busy1; s_done = done1; s_ovf = ovf1; s_bcd = {4'b0, bcd1};
            end
            2: begin
                s_busy = busy2; s_done = done2; s_ovf = ovf2; s_bcd = {16'b0, bcd2};
            end
            default: ;
        endcase
    end

    int n_vec = 0;
    int n_err = 0;
    logic [19:0] prev_exp [3];

    typedef struct {
        int          d;
        logic [15:0] b;
        logic [19:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic set_start(input int d, input logic v, input logic [15:0] b);
        case (d)
            1:       begin start1 = v; bin1 = b; end
            2:       begin start2 = v; bin2 = b[0:0]; end
            default: begin start0 = v; bin0 = b; end
        endcase
    endtask

    // Waits from the negedge after the accepting edge until done. The
    // latency returned is the number of cycles counted from that negedge.
    task automatic wait_done(input int d, output int cycles, output int busy_cnt,
                             output bit hold_ok);
        cycles   = 0;
        busy_cnt = 0;
        hold_ok  = 1'b1;
        while (!s_done && cycles < 60) begin
            if (s_busy) busy_cnt++;
            if (s_bcd !== prev_exp[d]) hold_ok = 1'b0;
            @(negedge clk);
            cycles++;
        end
    endtask

    // Call on a negedge. The task returns on the negedge of the done cycle.
    task automatic convert(input int d, input logic [15:0] b,
                           input logic [19:0] exp_bcd, input logic exp_ovf);
        int cycles, busy_cnt, exp_lat;
        bit hold_ok;
        exp_lat = (d == 2) ? 2 : 17;
        cur = d;
        set_start(d, 1'b1, b);
        @(posedge clk);
        @(negedge clk);
        set_start(d, 1'b0, 16'h0);
        wait_done(d, cycles, busy_cnt, hold_ok);
        $display("dut%0d bin=%0d bcd=%h ovf=%0b latency=%0d", d, b, s_bcd, s_ovf, cycles);
        chk("latency", cycles, exp_lat);
        chk("busy_cycles", busy_cnt, exp_lat);
        chk("bcd_hold", {31'b0, hold_ok}, 32'd1);
        chk("bcd", s_bcd, exp_bcd);
        chk("ovf", s_ovf, exp_ovf);
        chk("busy_at_done", s_busy, 0);
        prev_exp[d] = exp_bcd;
    endtask

    initial begin : main
        int cycles, busy_cnt, extra_done;
        bit hold_ok;

        tbl[0]  = '{0, 16'd0,     20'h00000, 1'b0};
        tbl[1]  = '{0, 16'd65535, 20'h65535, 1'b0};
        tbl[2]  = '{0, 16'd9,     20'h00009, 1'b0};
        tbl[3]  = '{0, 16'd10,    20'h00010, 1'b0};
        tbl[4]  = '{0, 16'd500,   20'h00500, 1'b0};
        tbl[5]  = '{0, 16'd777,   20'h00777, 1'b0};
        tbl[6]  = '{0, 16'd10000, 20'h10000, 1'b0};
        tbl[7]  = '{0, 16'd59999, 20'h59999, 1'b0};
        tbl[8]  = '{1, 16'd12345, 20'h02345, 1'b1};
        tbl[9]  = '{1, 16'd9999,  20'h09999, 1'b0};
        tbl[10] = '{1, 16'd10000, 20'h00000, 1'b1};
        tbl[11] = '{1, 16'd0,     20'h00000, 1'b0};
        tbl[12] = '{2, 16'd1,     20'h00001, 1'b0};
        tbl[13] = '{2, 16'd0,     20'h00000, 1'b0};
        tbl[14] = '{2, 16'd1,     20'h00001, 1'b0};

        rst_n  = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        bin0   = '0;   bin1   = '0;   bin2   = '0;
        cur    = 0;
        for (int i = 0; i < 3; i++) prev_exp[i] = '0;

        repeat (2) @(negedge clk);
        chk("reset_busy", busy0, 0);
        chk("reset_done", done0, 0);
        chk("reset_bcd", bcd0, 0);
        chk("reset_ovf", ovf0, 0);

        // Release reset and request on the same edge. The first start must
        // be accepted on the first rising edge.
        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            convert(tbl[i].d, tbl[i].b, tbl[i].exp_bcd, tbl[i].exp_ovf);
        end

        // A second start arrives while busy. It must be ignored.
        cur = 0;
        @(negedge clk);
        set_start(0, 1'b1, 16'd1234);
        @(posedge clk);
        @(negedge clk);
        set_start(0, 1'b0, 16'd0);
        repeat (5) @(negedge clk);
        set_start(0, 1'b1, 16'd4321);
        @(negedge clk);
        set_start(0, 1'b0, 16'd0);
        wait_done(0, cycles, busy_cnt, hold_ok);
        cycles += 6;
        $display("dut0 bin=1234 (4321 while busy) bcd=%h latency=%0d", s_bcd, cycles);
        chk("ignore_latency", cycles, 17);
        chk("ignore_bcd", s_bcd, 20'h01234);
        chk("ignore_ovf", s_ovf, 0);
        @(negedge clk);
        chk("done_one_cycle", s_done, 0);
        extra_done = 0;
        repeat (25) begin
            if (s_done) extra_done++;
            @(negedge clk);
        end
        chk("ignore_extra_done", extra_done, 0);
        chk("ignore_busy_after", s_busy, 0);

        // Assert reset during the conversion. It aborts without a clock edge.
        set_start(0, 1'b1, 16'd999);
        @(posedge clk);
        @(negedge clk);
        set_start(0, 1'b0, 16'd0);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("reset mid-conversion: busy=%0b done=%0b bcd=%h ovf=%0b", busy0, done0, bcd0, ovf0);
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
        chk("abort_bcd", bcd0, 0);
        chk("abort_ovf", ovf0, 0);
        chk("abort_bcd_dut2", bcd2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) prev_exp[i] = '0;
        extra_done = 0;
        repeat (25) begin
            if (s_done) extra_done++;
            @(negedge clk);
        end
        chk("abort_no_done", extra_done, 0);
        chk("abort_bcd_held", s_bcd, 0);
        convert(0, 16'd42, 20'h00042, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
